// File: rtl/hex_sb_ctrl_pkg.sv
// Shared register map and display constants for the multiplexed hex display peripheral.
package hex_sb_ctrl_pkg;

    localparam int          NUM_DIGITS = 8;
    localparam logic [31:0] DIGIT_BASE = 32'h0000_0000;
    localparam logic [31:0] MASK_ADDR  = 32'h0000_0020;
    localparam logic [31:0] RST_ADDR   = 32'h0000_0024;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam logic [7:0]  MASK_RESET = 8'hFF;

    // DIGIT0..DIGIT7 occupy word-aligned offsets 0x00..0x1C.
    function automatic logic is_digit_addr(input logic [31:0] addr);
        return (addr & ~32'h0000_001C) == DIGIT_BASE;
    endfunction

endpackage

// File: rtl/hex_sb_ctrl_dec.sv
// Hex value to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_digit_dec (
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        unique case (val_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_sb_ctrl.sv
// System-bus peripheral holding eight hex digits and an enable mask, and
// time-multiplexing them onto a common-segment seven-segment display.
module hex_sb_ctrl
    import hex_sb_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        req_i,
    input  logic        WE_i,
    input  logic [31:0] WD_i,
    output logic [31:0] RD_o,
    output logic [6:0]  hex_led_o,
    output logic [7:0]  hex_sel_o
);

    localparam int              CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [3:0]       digit_q [NUM_DIGITS];
    logic [3:0]       digit_d [NUM_DIGITS];
    logic [7:0]       mask_q, mask_d;
    logic [31:0]      rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sel_q, sel_d;
    logic [6:0]       led_q, led_d;
    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;
    logic             wr_en, rd_en;
    logic             unused_wd;

    assign unused_wd = ^WD_i[31:8];
    assign wr_en     = req_i && WE_i;
    assign rd_en     = req_i && !WE_i;

    always_comb begin
        digit_d = digit_q;
        mask_d  = mask_q;
        if (wr_en) begin
            if (is_digit_addr(addr_i)) begin
                digit_d[addr_i[4:2]] = WD_i[3:0];
            end else if (addr_i == MASK_ADDR) begin
                mask_d = WD_i[7:0];
            end else if (addr_i == RST_ADDR && WD_i[0]) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digit_d[i] = 4'h0;
                end
                mask_d = MASK_RESET;
            end
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            if (is_digit_addr(addr_i)) begin
                rd_d = {28'h0, digit_q[addr_i[4:2]]};
            end else if (addr_i == MASK_ADDR) begin
                rd_d = {24'h0, mask_q};
            end else begin
                rd_d = 32'h0;
            end
        end
    end

    // Scan divider: each index is held for SCAN_DIV cycles, outputs lag the index by one flop.
    assign cur_digit = digit_q[idx_q];

    hex_digit_dec u_dec (
        .val_i (cur_digit),
        .seg_o (cur_seg)
    );

    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
        end
        sel_d = ~((8'h01 << idx_q) & mask_q);
        led_d = mask_q[idx_q] ? cur_seg : SEG_BLANK;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 4'h0;
            end
            mask_q <= MASK_RESET;
            rd_q   <= 32'h0;
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            sel_q  <= 8'hFF;
            led_q  <= SEG_BLANK;
        end else begin
            digit_q <= digit_d;
            mask_q  <= mask_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            led_q   <= led_d;
        end
    end

    assign RD_o      = rd_q;
    assign hex_sel_o = sel_q;
    assign hex_led_o = led_q;

endmodule

// File: tb/tb_hex_sb_ctrl.sv
// Randomized bench for hex_sb_ctrl against an edge-count based reference model.
module tb_hex_sb_ctrl;

    localparam int SD = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        req_i = 1'b0;
    logic        WE_i = 1'b0;
    logic [31:0] WD_i = '0;
    logic [31:0] RD_o;
    logic [6:0]  hex_led_o;
    logic [7:0]  hex_sel_o;

    int vectors = 0;
    int miscompares = 0;

    hex_sb_ctrl #(.SCAN_DIV(SD)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .addr_i    (addr_i),
        .req_i     (req_i),
        .WE_i      (WE_i),
        .WD_i      (WD_i),
        .RD_o      (RD_o),
        .hex_led_o (hex_led_o),
        .hex_sel_o (hex_sel_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: register file plus an edge counter since reset release.
    logic [3:0]  m_digit [8];
    logic [7:0]  m_mask;
    logic [31:0] m_rd;
    logic [7:0]  exp_sel;
    logic [6:0]  exp_led;
    int          n_edges;

    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic int scan_idx(input int n);
        return (n / SD) % 8;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a <= 32'h1C && a[1:0] == 2'b00) return {28'h0, m_digit[a / 4]};
        if (a == 32'h20) return {24'h0, m_mask};
        return 32'h0;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) m_digit[i] <= 4'h0;
            m_mask  <= 8'hFF;
            m_rd    <= 32'h0;
            exp_sel <= 8'hFF;
            exp_led <= 7'h7F;
            n_edges <= 0;
        end else begin
            exp_sel <= m_mask[scan_idx(n_edges)] ? ~(8'h01 << scan_idx(n_edges)) : 8'hFF;
            exp_led <= m_mask[scan_idx(n_edges)] ? seg_ref(m_digit[scan_idx(n_edges)]) : 7'h7F;
            n_edges <= n_edges + 1;
            if (req_i && WE_i) begin
                if (addr_i <= 32'h1C && addr_i[1:0] == 2'b00) m_digit[addr_i / 4] <= WD_i[3:0];
                else if (addr_i == 32'h20) m_mask <= WD_i[7:0];
                else if (addr_i == 32'h24 && WD_i[0]) begin
                    for (int i = 0; i < 8; i++) m_digit[i] <= 4'h0;
                    m_mask <= 8'hFF;
                end
            end
            if (req_i && !WE_i) m_rd <= m_read(addr_i);
        end
    end

    // Drive one bus cycle and advance to the following falling edge.
    task automatic bus(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        req_i = req; WE_i = we; addr_i = addr; WD_i = wd;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        vectors++;
        if (hex_sel_o !== 8'hFF || hex_led_o !== 7'h7F || RD_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: sel=%h led=%h rd=%h, want FF 7F 0", hex_sel_o, hex_led_o, RD_o);
        end
        rst_i = 1'b0;
        bus(0, 0, 0, 0);
        vectors++;
        if (hex_sel_o !== 8'hFE || hex_led_o !== 7'h40) begin
            miscompares++;
            $display("FAIL first_digit: sel=%h led=%h, want FE 40", hex_sel_o, hex_led_o);
        end
    endtask

    task automatic test_scan();
        for (int c = 0; c < 8 * SD + 6; c++) begin
            bus(0, 0, 0, 0);
            vectors++;
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led) begin
                miscompares++;
                $display("FAIL scan c=%0d: sel=%h led=%h, want %h %h", c, hex_sel_o, hex_led_o, exp_sel, exp_led);
            end
        end
    endtask

    task automatic test_write_digits();
        bus(1, 1, 32'h00, 32'h5);
        bus(1, 1, 32'h04, 32'hA);
        bus(1, 1, 32'h20, 32'h03);
        for (int c = 0; c < 8 * SD + 6; c++) begin
            bus(0, 0, 0, 0);
            vectors++;
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led) begin
                miscompares++;
                $display("FAIL mask_scan c=%0d: sel=%h led=%h, want %h %h", c, hex_sel_o, hex_led_o, exp_sel, exp_led);
            end
            if (hex_sel_o == 8'hFE && hex_led_o !== 7'h12) begin
                miscompares++;
                $display("FAIL digit0_seg: led=%h, want 12", hex_led_o);
            end
            if (hex_sel_o == 8'hFD && hex_led_o !== 7'h08) begin
                miscompares++;
                $display("FAIL digit1_seg: led=%h, want 08", hex_led_o);
            end
        end
    endtask

    task automatic test_readback();
        bus(1, 1, 32'h04, 32'hFFFF_FFFB);
        bus(1, 0, 32'h04, 32'h0);
        vectors++;
        if (RD_o !== 32'h0000_000B) begin
            miscompares++;
            $display("FAIL read_digit1: rd=%h, want 0000000B", RD_o);
        end
        for (int c = 0; c < 3; c++) begin
            bus(0, 0, 32'h20, 32'h0);
            vectors++;
            if (RD_o !== 32'h0000_000B) begin
                miscompares++;
                $display("FAIL rd_hold: rd=%h, want 0000000B", RD_o);
            end
        end
        bus(1, 0, 32'h30, 32'h0);
        vectors++;
        if (RD_o !== 32'h0) begin
            miscompares++;
            $display("FAIL read_unmapped: rd=%h, want 0", RD_o);
        end
    endtask

    task automatic test_rst_reg();
        for (int i = 0; i < 8; i++) bus(1, 1, i * 4, $urandom | 32'h1);
        bus(1, 1, 32'h20, 32'h5A);
        bus(1, 1, 32'h24, 32'hFFFF_FFFE);
        bus(1, 0, 32'h20, 32'h0);
        vectors++;
        if (RD_o !== 32'h5A) begin
            miscompares++;
            $display("FAIL rst_bit0_clear: mask rd=%h, want 5A", RD_o);
        end
        bus(1, 1, 32'h24, 32'h1);
        for (int a = 0; a <= 32'h24; a += 4) begin
            bus(1, 0, a, 32'h0);
            vectors++;
            if (RD_o !== ((a == 32'h20) ? 32'hFF : 32'h0) || RD_o !== m_rd) begin
                miscompares++;
                $display("FAIL rst_reg a=%h: rd=%h, want %h", a, RD_o, m_rd);
            end
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led) begin
                miscompares++;
                $display("FAIL rst_phase: sel=%h led=%h, want %h %h", hex_sel_o, hex_led_o, exp_sel, exp_led);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int op;
        for (int c = 0; c < 400; c++) begin
            op = $urandom_range(0, 2);
            a  = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 11) * 4;
            bus(op != 0, op == 1, a, $urandom);
            vectors++;
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led || RD_o !== m_rd) begin
                miscompares++;
                $display("FAIL random c=%0d: sel=%h led=%h rd=%h, want %h %h %h",
                         c, hex_sel_o, hex_led_o, RD_o, exp_sel, exp_led, m_rd);
            end
        end
    endtask

    task automatic test_mask_zero();
        bus(1, 1, 32'h20, 32'hFFFF_FF00);
        for (int c = 0; c < 8 * SD + 2; c++) begin
            bus(0, 0, 0, 0);
            vectors++;
            if (c > 0 && (hex_sel_o !== 8'hFF || hex_led_o !== 7'h7F)) begin
                miscompares++;
                $display("FAIL mask_zero: sel=%h led=%h, want FF 7F", hex_sel_o, hex_led_o);
            end
        end
        bus(1, 1, 32'h20, 32'hFF);
        bus(0, 0, 0, 0);
        vectors++;
        if (hex_sel_o !== exp_sel || hex_led_o !== exp_led) begin
            miscompares++;
            $display("FAIL mask_restore: sel=%h led=%h, want %h %h", hex_sel_o, hex_led_o, exp_sel, exp_led);
        end
    endtask

    task automatic test_async_reset();
        bus(1, 1, 32'h20, 32'hFF);
        bus(1, 0, 32'h20, 32'h0);
        repeat (SD + 1) bus(0, 0, 0, 0);
        req_i = 1'b1; WE_i = 1'b1; addr_i = 32'h0; WD_i = 32'h9;
        #2 rst_i = 1'b1;
        #1;
        vectors++;
        if (hex_sel_o !== 8'hFF || hex_led_o !== 7'h7F || RD_o !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: sel=%h led=%h rd=%h, want FF 7F 0", hex_sel_o, hex_led_o, RD_o);
        end
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        bus(0, 0, 0, 0);
        vectors++;
        if (hex_sel_o !== 8'hFE || hex_led_o !== 7'h40) begin
            miscompares++;
            $display("FAIL restart_digit0: sel=%h led=%h, want FE 40", hex_sel_o, hex_led_o);
        end
        bus(1, 0, 32'h0, 32'h0);
        vectors++;
        if (RD_o !== 32'h0) begin
            miscompares++;
            $display("FAIL write_dropped: rd=%h, want 0", RD_o);
        end
    endtask

    task automatic test_unmapped();
        for (int i = 0; i < 8; i++) bus(1, 1, i * 4, $urandom);
        bus(1, 1, 32'h20, $urandom);
        bus(1, 1, 32'h28, 32'hFFFF_FFFF);
        bus(1, 1, 32'h0000_0002, 32'h0000_0007);
        bus(1, 1, 32'h0000_0100, 32'h0000_0003);
        for (int a = 0; a <= 32'h24; a += 4) begin
            bus(1, 0, a, 32'h0);
            vectors++;
            if (RD_o !== m_rd) begin
                miscompares++;
                $display("FAIL unmapped_wr a=%h: rd=%h, want %h", a, RD_o, m_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write_digits();
        test_readback();
        test_rst_reg();
        test_random();
        test_mask_zero();
        test_async_reset();
        test_unmapped();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
